// File: rtl/spi_boot_pkg.sv
// spi_boot_pkg: shared types and constants for the SPI boot loader.
//   boot_state_e  - boot sequencer states
//   CMD_WRITE_MEM - SPI slave "write memory" opcode
//   CMD_BITS      - opcode length in bits
//   WORD_BITS     - address / data word length in bits
package spi_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_FETCH,
    ST_DATA,
    ST_HOLD,
    ST_DONE
  } boot_state_e;

  localparam logic [7:0] CMD_WRITE_MEM = 8'h02;
  localparam int         CMD_BITS      = 8;
  localparam int         WORD_BITS     = 32;

endpackage

// File: rtl/spi_boot_shifter.sv
// spi_boot_shifter: SPI mode-0 bit engine. Generates SCK from a half-period
// down-counter, shifts a word out MSB first and counts the remaining bits.
//   clk, rst   - system clock, synchronous active-high reset
//   load       - load data/nbits, restart in the SCK-low phase
//   en         - advance the divider and shifting
//   data       - word to send, left-aligned (bit 31 goes first)
//   nbits      - number of bits to send (1..32)
//   sck, sdo   - SPI clock and data out
//   bit_done   - last cycle of a bit (end of the SCK-high phase)
//   word_done  - last cycle of the final bit
module spi_boot_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [5:0]  nbits,
  output logic        sck,
  output logic        sdo,
  output logic        bit_done,
  output logic        word_done
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0]  div_q;
  logic        sck_q;
  logic [31:0] sh_q;
  logic [5:0]  cnt_q;
  logic        div_tc;

  assign div_tc = (div_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_M1;
      sck_q <= 1'b0;
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= DIV_M1;
      sck_q <= 1'b0;
      sh_q  <= data;
      cnt_q <= nbits;
    end else if (en) begin
      if (div_tc) begin
        div_q <= DIV_M1;
        sck_q <= ~sck_q;
        // Shift at the end of the high phase so sdo changes on the
        // first cycle of the next low phase.
        if (sck_q) begin
          sh_q  <= {sh_q[30:0], 1'b0};
          cnt_q <= cnt_q - 6'd1;
        end
      end else begin
        div_q <= div_q - 8'd1;
      end
    end
  end

  assign sck       = sck_q;
  assign sdo       = sh_q[31];
  assign bit_done  = div_tc & sck_q;
  assign word_done = bit_done & (cnt_q == 6'd1);

endmodule

// File: rtl/spi_boot_loader.sv
// spi_boot_loader: streams 32-bit program words into the PULPino SPI slave
// as one write-memory transaction, then raises fetch enable (one-shot).
//   clk, rst        - system clock, synchronous active-high reset
//   start_i         - pulse, begins a load when idle
//   load_addr_i     - target byte address, sampled with start_i
//   wr_valid_i/wr_data_i/wr_last_i/wr_ready_o - program word stream
//   spi_clk_o, spi_cs_o, spi_sdo_o - SPI master pins (mode 0, CS active low)
//   fetch_enable_o  - high once the image is written
//   busy_o          - transaction in progress
//   words_o         - words accepted in current/last load (saturating)
//   checksum_o      - running sum of accepted words
// Build option: define SPI_BOOT_CHECKSUM_EN to implement checksum_o;
// otherwise it is tied to zero.
//
// state | meaning
// IDLE  | waiting for start_i, CS high
// SETUP | CS low, SCK low for CLK_DIV cycles
// CMD   | shifting the 8-bit write-memory opcode
// ADDR  | shifting the 32-bit target address
// FETCH | SCK low, waiting for a stream word (unbounded stall)
// DATA  | shifting one 32-bit data word
// HOLD  | CS low, SCK low for CLK_DIV cycles after the last word
// DONE  | CS high, fetch enable high until reset
module spi_boot_loader
  import spi_boot_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] load_addr_i,
  input  logic        wr_valid_i,
  input  logic [31:0] wr_data_i,
  input  logic        wr_last_i,
  output logic        wr_ready_o,
  output logic        spi_clk_o,
  output logic        spi_cs_o,
  output logic        spi_sdo_o,
  output logic        fetch_enable_o,
  output logic        busy_o,
  output logic [15:0] words_o,
  output logic [31:0] checksum_o
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  boot_state_e state_q, state_d;

  logic [31:0] addr_q;
  logic [7:0]  tmr_q;
  logic        last_q;
  logic [15:0] words_q;

  logic        launch;
  logic        accept;
  logic        tmr_start;

  logic        sh_load;
  logic        sh_en;
  logic [31:0] sh_data;
  logic [5:0]  sh_nbits;
  logic        sh_sck;
  logic        sh_sdo;
  logic        sh_bit_done;
  logic        sh_word_done;
  logic        shift_end;

  assign shift_end = sh_bit_done & sh_word_done;
  assign sh_en     = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_DATA);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    launch         = 1'b0;
    accept         = 1'b0;
    tmr_start      = 1'b0;
    sh_load        = 1'b0;
    sh_data        = '0;
    sh_nbits       = '0;
    wr_ready_o     = 1'b0;
    busy_o         = 1'b0;
    fetch_enable_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          launch    = 1'b1;
          tmr_start = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        busy_o = 1'b1;
        if (tmr_q == 8'd0) begin
          sh_load  = 1'b1;
          sh_data  = {CMD_WRITE_MEM, 24'h0};
          sh_nbits = 6'(CMD_BITS);
          state_d  = ST_CMD;
        end
      end
      ST_CMD: begin
        busy_o = 1'b1;
        if (shift_end) begin
          sh_load  = 1'b1;
          sh_data  = addr_q;
          sh_nbits = 6'(WORD_BITS);
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        busy_o = 1'b1;
        if (shift_end) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busy_o     = 1'b1;
        wr_ready_o = 1'b1;
        if (wr_valid_i) begin
          accept   = 1'b1;
          sh_load  = 1'b1;
          sh_data  = wr_data_i;
          sh_nbits = 6'(WORD_BITS);
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        busy_o = 1'b1;
        if (shift_end) begin
          if (last_q) begin
            tmr_start = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            state_d   = ST_FETCH;
          end
        end
      end
      ST_HOLD: begin
        busy_o = 1'b1;
        if (tmr_q == 8'd0) state_d = ST_DONE;
      end
      ST_DONE: begin
        fetch_enable_o = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      tmr_q   <= '0;
      last_q  <= 1'b0;
      words_q <= '0;
    end else begin
      if (launch) begin
        addr_q  <= load_addr_i;
        words_q <= '0;
      end
      if (tmr_start)            tmr_q <= DIV_M1;
      else if (tmr_q != 8'd0)   tmr_q <= tmr_q - 8'd1;
      if (accept) begin
        last_q <= wr_last_i;
        if (words_q != 16'hFFFF) words_q <= words_q + 16'd1;
      end
    end
  end

`ifdef SPI_BOOT_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst)         csum_q <= '0;
    else if (launch) csum_q <= '0;
    else if (accept) csum_q <= csum_q + wr_data_i;
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

  spi_boot_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .en        (sh_en),
    .data      (sh_data),
    .nbits     (sh_nbits),
    .sck       (sh_sck),
    .sdo       (sh_sdo),
    .bit_done  (sh_bit_done),
    .word_done (sh_word_done)
  );

  // SCK idles low outside shifting; sdo is forced low while CS is high.
  assign spi_clk_o = sh_sck;
  assign spi_cs_o  = ~busy_o;
  assign spi_sdo_o = busy_o & sh_sdo;
  assign words_o   = words_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
// tb_spi_boot_loader: two instances (CLK_DIV=2 and CLK_DIV=1) driven one at
// a time. An SPI slave model decodes each CS-low frame into an address-keyed
// memory; expectations come from the word lists and the frame timing formula.
module tb_spi_boot_loader;

  localparam int DIV0 = 2;
  localparam int DIV1 = 1;

  logic        clk = 1'b0;
  logic        rst       [2];
  logic        start     [2];
  logic [31:0] load_addr [2];
  logic        wr_valid  [2];
  logic [31:0] wr_data   [2];
  logic        wr_last   [2];
  logic        wr_ready  [2];
  logic        sck       [2];
  logic        cs        [2];
  logic        sdo       [2];
  logic        fe        [2];
  logic        busy      [2];
  logic [15:0] words     [2];
  logic [31:0] csum      [2];

  always #5 clk = ~clk;

  spi_boot_loader #(.CLK_DIV(DIV0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .start_i(start[0]), .load_addr_i(load_addr[0]),
    .wr_valid_i(wr_valid[0]), .wr_data_i(wr_data[0]), .wr_last_i(wr_last[0]),
    .wr_ready_o(wr_ready[0]), .spi_clk_o(sck[0]), .spi_cs_o(cs[0]),
    .spi_sdo_o(sdo[0]), .fetch_enable_o(fe[0]), .busy_o(busy[0]),
    .words_o(words[0]), .checksum_o(csum[0])
  );

  spi_boot_loader #(.CLK_DIV(DIV1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .start_i(start[1]), .load_addr_i(load_addr[1]),
    .wr_valid_i(wr_valid[1]), .wr_data_i(wr_data[1]), .wr_last_i(wr_last[1]),
    .wr_ready_o(wr_ready[1]), .spi_clk_o(sck[1]), .spi_cs_o(cs[1]),
    .spi_sdo_o(sdo[1]), .fetch_enable_o(fe[1]), .busy_o(busy[1]),
    .words_o(words[1]), .checksum_o(csum[1])
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- SPI slave model (only one instance active at a time)
  logic        cs_prev  [2];
  logic        sck_prev [2];
  bit          rx_bits [$];
  logic [31:0] rx_mem [logic [31:0]];
  int          cs_falls   = 0;
  int          cs_rises   = 0;
  int          cs_low_cnt = 0;
  int          first_rise = 0;
  int          last_rise  = 0;
  int          min_per    = 0;
  int          rx_nbits   = 0;
  logic [7:0]  rx_cmd     = '0;
  logic [31:0] rx_addr    = '0;
  logic        fe_at_rise = 1'b0;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cs[k] === 1'b0) begin
        if (cs_prev[k] === 1'b1) begin
          cs_falls++;
          cs_low_cnt = 1;
          rx_bits.delete();
          rx_mem.delete();
          first_rise = 0;
          min_per    = 1000000;
        end else begin
          cs_low_cnt++;
        end
        if (sck[k] === 1'b1 && sck_prev[k] === 1'b0) begin
          rx_bits.push_back(sdo[k]);
          if (first_rise == 0) first_rise = cs_low_cnt;
          else if (cs_low_cnt - last_rise < min_per) min_per = cs_low_cnt - last_rise;
          last_rise = cs_low_cnt;
        end
      end else if (cs[k] === 1'b1 && cs_prev[k] === 1'b0) begin
        cs_rises++;
        fe_at_rise = fe[k];
        rx_nbits   = rx_bits.size();
        if (rx_nbits >= 40) begin
          logic [31:0] w;
          rx_cmd  = '0;
          rx_addr = '0;
          for (int i = 0; i < 8; i++)  rx_cmd  = {rx_cmd[6:0], rx_bits[i]};
          for (int i = 8; i < 40; i++) rx_addr = {rx_addr[30:0], rx_bits[i]};
          for (int n = 0; n < (rx_nbits - 40) / 32; n++) begin
            w = '0;
            for (int b = 0; b < 32; b++) w = {w[30:0], rx_bits[40 + 32*n + b]};
            rx_mem[rx_addr + 32'(4*n)] = w;
          end
        end
      end
      cs_prev[k]  = cs[k];
      sck_prev[k] = sck[k];
    end
  end

  // ---------------- stimulus helpers
  logic [31:0] tx_words [$];
  int          tx_stall [$];

  task automatic do_reset(input int k);
    rst[k] = 1'b1; start[k] = 1'b0; wr_valid[k] = 1'b0; wr_last[k] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cs",    32'(cs[k]),       32'd1);
    chk("rst_sck",   32'(sck[k]),      32'd0);
    chk("rst_sdo",   32'(sdo[k]),      32'd0);
    chk("rst_ready", 32'(wr_ready[k]), 32'd0);
    chk("rst_fe",    32'(fe[k]),       32'd0);
    chk("rst_busy",  32'(busy[k]),     32'd0);
    chk("rst_words", 32'(words[k]),    32'd0);
    chk("rst_csum",  csum[k],          32'd0);
    rst[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input int k, input logic [31:0] a);
    start[k] = 1'b1; load_addr[k] = a;
    @(negedge clk);
    start[k] = 1'b0; load_addr[k] = $urandom;
  endtask

  task automatic run_load(input int k, input logic [31:0] a, input bit mid_start);
    int d, n, stall_sum, falls0, rises0, cnt, exp_low;
    logic [31:0] sum;
    d = (k == 0) ? DIV0 : DIV1;
    n = tx_words.size();
    stall_sum = 0; sum = '0;
    falls0 = cs_falls; rises0 = cs_rises;
    pulse_start(k, a);
    chk("cs_fall_next", 32'(cs[k]), 32'd0);
    chk("busy_run", 32'(busy[k]), 32'd1);
    for (int i = 0; i < n; i++) begin
      cnt = 0;
      while (wr_ready[k] !== 1'b1 && cnt < 20000) begin @(negedge clk); cnt++; end
      if (wr_ready[k] !== 1'b1) begin
        chk("ready_timeout", 32'd0, 32'd1);
        return;
      end
      repeat (tx_stall[i]) @(negedge clk);
      if (tx_stall[i] > 0) begin
        chk("stall_sck", 32'(sck[k]), 32'd0);
        chk("stall_cs",  32'(cs[k]),  32'd0);
      end
      stall_sum += tx_stall[i];
      wr_valid[k] = 1'b1; wr_data[k] = tx_words[i]; wr_last[k] = (i == n - 1);
      @(negedge clk);
      wr_valid[k] = 1'b0; wr_last[k] = 1'b0; wr_data[k] = $urandom;
      sum += tx_words[i];
      chk("words_run", 32'(words[k]), 32'(i + 1));
`ifdef SPI_BOOT_CHECKSUM_EN
      chk("csum_run", csum[k], sum);
`else
      chk("csum_run", csum[k], 32'd0);
`endif
      if (mid_start && i == 0) begin
        repeat (5) @(negedge clk);
        start[k] = 1'b1; load_addr[k] = 32'hFFFF_FFF0;
        @(negedge clk);
        start[k] = 1'b0;
      end
    end
    cnt = 0;
    while (fe[k] !== 1'b1 && cnt < 20000) begin @(negedge clk); cnt++; end
    chk("fe_seen", 32'(fe[k]), 32'd1);
    @(negedge clk);
    exp_low = d + 80*d + n*(64*d + 1) + d + stall_sum;
    chk("cs_falls",   32'(cs_falls - falls0), 32'd1);
    chk("cs_rises",   32'(cs_rises - rises0), 32'd1);
    chk("fe_with_cs", 32'(fe_at_rise),        32'd1);
    chk("cs_low_len", 32'(cs_low_cnt),        32'(exp_low));
    chk("first_rise", 32'(first_rise),        32'(2*d + 1));
    chk("sck_period", 32'(min_per),           32'(2*d));
    chk("rx_nbits",   32'(rx_nbits),          32'(40 + 32*n));
    chk("rx_cmd",     32'(rx_cmd),            32'h02);
    chk("rx_addr",    rx_addr,                a);
    for (int i = 0; i < n; i++)
      chk("rx_mem", rx_mem.exists(a + 32'(4*i)) ? rx_mem[a + 32'(4*i)] : 32'hxxxx_xxxx,
          tx_words[i]);
    chk("words_done", 32'(words[k]), 32'(n));
`ifdef SPI_BOOT_CHECKSUM_EN
    chk("csum_done", csum[k], sum);
`else
    chk("csum_done", csum[k], 32'd0);
`endif
    chk("busy_done", 32'(busy[k]), 32'd0);
    pulse_start(k, 32'h0000_1000);
    repeat (10) @(negedge clk);
    chk("oneshot_cs",    32'(cs[k]),              32'd1);
    chk("oneshot_fe",    32'(fe[k]),              32'd1);
    chk("oneshot_falls", 32'(cs_falls - falls0),  32'd1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; load_addr[k] = '0;
      wr_valid[k] = 1'b0; wr_data[k] = '0; wr_last[k] = 1'b0;
    end

    // one word, valid always, CLK_DIV=2
    do_reset(0);
    tx_words = '{32'hDEADBEEF}; tx_stall = '{0};
    run_load(0, 32'h0000_0000, 1'b0);
    chk("cs_low_293", 32'(cs_low_cnt), 32'd293);

    // four words into 0x100000
    do_reset(0);
    tx_words = '{32'd1, 32'd2, 32'd3, 32'd4}; tx_stall = '{0, 0, 0, 0};
    run_load(0, 32'h0010_0000, 1'b0);

    // 50-cycle stall between words 1 and 2, start pulsed during DATA
    do_reset(0);
    tx_words = '{32'h1111_2222, 32'h3333_4444}; tx_stall = '{0, 50};
    run_load(0, 32'h0000_0400, 1'b1);
    chk("cs_low_stall", 32'(cs_low_cnt), 32'd472);

    // reset in the middle of the address phase, then a fresh load
    do_reset(0);
    pulse_start(0, 32'h0000_0800);
    repeat (50) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_cs",    32'(cs[0]),       32'd1);
    chk("midrst_sck",   32'(sck[0]),      32'd0);
    chk("midrst_busy",  32'(busy[0]),     32'd0);
    chk("midrst_ready", 32'(wr_ready[0]), 32'd0);
    chk("midrst_fe",    32'(fe[0]),       32'd0);
    rst[0] = 1'b0;
    @(negedge clk);
    tx_words = '{32'hCAFE_F00D, 32'h0BAD_BEEF}; tx_stall = '{3, 0};
    run_load(0, 32'h0000_0800, 1'b0);

    // CLK_DIV=1 instance
    do_reset(1);
    tx_words = '{32'hA5A5_A5A5}; tx_stall = '{0};
    run_load(1, 32'h0000_0040, 1'b0);

    // randomized loads
    for (int r = 0; r < 6; r++) begin
      int k, n;
      k = $urandom_range(0, 1);
      n = $urandom_range(1, 5);
      tx_words.delete(); tx_stall.delete();
      for (int i = 0; i < n; i++) begin
        tx_words.push_back($urandom);
        tx_stall.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0);
      end
      do_reset(k);
      run_load(k, $urandom & 32'hFFFF_FFFC, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
